// File: rtl/i2c_ctrl_pkg.sv
// Shared definitions for the Si5341A I2C byte engine: one-hot states, quarter-phase codes
// and the SCL quarter-period derivation.
package i2c_ctrl_pkg;

    typedef enum logic [7:0] {
        IDLE        = 8'h01,
        WR_START    = 8'h02,
        WR_DEV_ADDR = 8'h04,
        WR_REG_ADDR = 8'h08,
        WR_DATA     = 8'h10,
        RD_START    = 8'h20,
        RD_DATA     = 8'h40,
        STOP        = 8'h80
    } state_t;

    // Quarter phases of one bit: two with SCL low, then two with SCL high.
    localparam logic [1:0] PH_LO0 = 2'd0;
    localparam logic [1:0] PH_LO1 = 2'd1;
    localparam logic [1:0] PH_HI0 = 2'd2;
    localparam logic [1:0] PH_HI1 = 2'd3;

    function automatic int unsigned qtr_calc(input int unsigned sys_clk,
                                             input int unsigned scl_clk);
        return sys_clk / (scl_clk * 4);
    endfunction

endpackage

// File: rtl/i2c_master_fsm.sv
// I2C master sequencer: state register, quarter-phase timer, bit counter and shift registers.
// States: IDLE bus free | WR_START start | WR_* address/data bytes | RD_START rep-start + addr | RD_DATA read | STOP
module i2c_master_fsm
    import i2c_ctrl_pkg::*;
#(
    parameter int unsigned SYS_CLK = 50_000_000,
    parameter int unsigned SCL_CLK = 400_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rd_req,
    input  logic       wr_req,
    input  logic [7:0] wr_data,
    input  logic       sda_in,
    output logic [7:0] rd_data,
    output logic       rd_done,
    output logic       wr_done,
    output logic       scl,
    output logic       sda_out,
    output logic       is_out
);

    localparam int unsigned     QTR    = qtr_calc(SYS_CLK, SCL_CLK);
    localparam int              QW     = (QTR > 1) ? $clog2(QTR) : 1;
    localparam logic [QW-1:0]   QTR_M1 = QW'(QTR - 1);

    state_t        state_r, state_nx;
    logic [QW-1:0] qcnt_r;
    logic [1:0]    phase_r;
    logic [3:0]    bcnt_r;
    logic [7:0]    tx_sr, rx_sr;
    logic [6:0]    dev_addr_r;
    logic          rd_flag_r, rs_pend_r, ack_r;

    logic qtc, bit_end, smp, ld, ack_bit, byte_st;
    logic scl_c, sda_c, oe_c, wr_done_c, rd_done_c;

    assign qtc     = (qcnt_r == '0);
    assign bit_end = qtc && (phase_r == PH_HI1);
    assign smp     = qtc && (phase_r == PH_HI0);
    assign ld      = qtc && (phase_r == PH_LO0) && (bcnt_r == 4'd0);
    assign ack_bit = (bcnt_r == 4'd8);
    assign byte_st = (state_r == WR_DEV_ADDR) || (state_r == WR_REG_ADDR) ||
                     (state_r == WR_DATA) || ((state_r == RD_START) && !rs_pend_r);

    always_ff @(posedge clk) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= state_nx;
    end

    always_comb begin
        state_nx  = state_r;
        scl_c     = 1'b1;
        sda_c     = 1'b1;
        oe_c      = 1'b1;
        wr_done_c = 1'b0;
        rd_done_c = 1'b0;
        case (state_r)
            IDLE: begin
                if (wr_req || rd_req) state_nx = WR_START;
            end
            WR_START: begin
                scl_c = (phase_r != PH_HI1);
                sda_c = (phase_r == PH_LO0);
                if (bit_end) state_nx = WR_DEV_ADDR;
            end
            WR_DEV_ADDR, WR_REG_ADDR, WR_DATA: begin
                scl_c = phase_r[1];
                if (ack_bit) oe_c  = 1'b0;
                else         sda_c = tx_sr[7];
                // A burst ends when the host has dropped wr_req by the next byte's load point.
                if ((state_r == WR_DATA) && ld && !wr_req) begin
                    state_nx = STOP;
                end else if (bit_end && ack_bit) begin
                    if (ack_r) begin
                        state_nx = STOP;
                    end else begin
                        wr_done_c = 1'b1;
                        case (state_r)
                            WR_DEV_ADDR: state_nx = WR_REG_ADDR;
                            WR_REG_ADDR: state_nx = rd_flag_r ? RD_START : WR_DATA;
                            default:     state_nx = wr_req ? WR_DATA : STOP;
                        endcase
                    end
                end
            end
            RD_START: begin
                if (rs_pend_r) begin
                    scl_c = (phase_r == PH_LO1) || (phase_r == PH_HI0);
                    sda_c = (phase_r == PH_LO0) || (phase_r == PH_LO1);
                end else begin
                    scl_c = phase_r[1];
                    if (ack_bit) oe_c  = 1'b0;
                    else         sda_c = tx_sr[7];
                    if (bit_end && ack_bit) state_nx = ack_r ? STOP : RD_DATA;
                end
            end
            RD_DATA: begin
                scl_c = phase_r[1];
                oe_c  = ack_bit;
                if (bit_end && ack_bit) begin
                    rd_done_c = 1'b1;
                    state_nx  = STOP;
                end
            end
            STOP: begin
                if (bcnt_r == 4'd0) begin
                    scl_c = (phase_r != PH_LO0);
                    sda_c = phase_r[1];
                end
                if (bit_end && (bcnt_r == 4'd1)) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            qcnt_r  <= QTR_M1;
            phase_r <= PH_LO0;
            bcnt_r  <= 4'd0;
        end else if ((state_r == IDLE) || (state_nx != state_r)) begin
            qcnt_r  <= QTR_M1;
            phase_r <= PH_LO0;
            bcnt_r  <= 4'd0;
        end else if (qtc) begin
            qcnt_r  <= QTR_M1;
            phase_r <= phase_r + 2'd1;
            if (phase_r == PH_HI1)
                bcnt_r <= (ack_bit || ((state_r == RD_START) && rs_pend_r)) ? 4'd0 : bcnt_r + 4'd1;
        end else begin
            qcnt_r <= qcnt_r - QW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_sr      <= 8'h00;
            rx_sr      <= 8'h00;
            dev_addr_r <= 7'h00;
            rd_flag_r  <= 1'b0;
            rs_pend_r  <= 1'b1;
            ack_r      <= 1'b1;
        end else begin
            if ((state_r == IDLE) && (state_nx == WR_START)) rd_flag_r <= !wr_req;
            if (state_r != RD_START) rs_pend_r <= 1'b1;
            else if (bit_end)        rs_pend_r <= 1'b0;
            if (byte_st && ld)
                tx_sr <= (state_r == RD_START) ? {dev_addr_r, 1'b1} : wr_data;
            else if (byte_st && bit_end && !ack_bit)
                tx_sr <= {tx_sr[6:0], 1'b0};
            if ((state_r == WR_DEV_ADDR) && ld) dev_addr_r <= wr_data[7:1];
            if (smp) begin
                ack_r <= sda_in;
                if ((state_r == RD_DATA) && !ack_bit) rx_sr <= {rx_sr[6:0], sda_in};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl     <= 1'b1;
            sda_out <= 1'b1;
            is_out  <= 1'b1;
            wr_done <= 1'b0;
            rd_done <= 1'b0;
            rd_data <= 8'h00;
        end else begin
            scl     <= scl_c;
            sda_out <= sda_c;
            is_out  <= oe_c;
            wr_done <= wr_done_c;
            rd_done <= rd_done_c;
            if (rd_done_c) rd_data <= rx_sr;
        end
    end

endmodule

// File: rtl/i2c_ctrl.sv
// I2C byte engine top: SDA pad tristate around the master sequencer.
// Define I2C_OPEN_DRAIN_EN to never drive SDA high (released instead); default is push-pull.
module i2c_ctrl
    import i2c_ctrl_pkg::*;
#(
    parameter int unsigned SYS_CLK = 50_000_000,
    parameter int unsigned SCL_CLK = 400_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rd_req,
    input  logic       wr_req,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_data,
    output logic       rd_done,
    output logic       wr_done,
    output logic       i2c_scl,
    inout  wire        i2c_sda,
    output logic       is_out
);

    logic sda_o;
    logic sda_i;

    i2c_master_fsm #(
        .SYS_CLK (SYS_CLK),
        .SCL_CLK (SCL_CLK)
    ) u1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_req  (rd_req),
        .wr_req  (wr_req),
        .wr_data (wr_data),
        .sda_in  (sda_i),
        .rd_data (rd_data),
        .rd_done (rd_done),
        .wr_done (wr_done),
        .scl     (i2c_scl),
        .sda_out (sda_o),
        .is_out  (is_out)
    );

`ifdef I2C_OPEN_DRAIN_EN
    assign i2c_sda = (is_out && !sda_o) ? 1'b0 : 1'bz;
`else
    assign i2c_sda = is_out ? sda_o : 1'bz;
`endif

    assign sda_i = i2c_sda;

endmodule

// File: tb/tb_i2c_ctrl.sv
// Directed bench for i2c_ctrl: write burst, random read, slave NACK and reset, against a bus monitor/slave.
module tb_i2c_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rd_req = 1'b0;
    logic       wr_req = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic [7:0] rd_data;
    logic       rd_done, wr_done, i2c_scl, is_out;
    wire        i2c_sda;

    logic       slv_low = 1'b0;
    logic       ack_en = 1'b1;
    logic [7:0] slv_byte = 8'h5A;

    int n_checks = 0;
    int n_errors = 0;

    always #10 clk = ~clk;

    pullup (i2c_sda);
    assign i2c_sda = (slv_low && !is_out) ? 1'b0 : 1'bz;

    i2c_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_req  (rd_req),
        .wr_req  (wr_req),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .rd_done (rd_done),
        .wr_done (wr_done),
        .i2c_scl (i2c_scl),
        .i2c_sda (i2c_sda),
        .is_out  (is_out)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bus monitor and slave model, sampled on the falling clk edge.
    logic       prev_scl = 1'b1, prev_sda = 1'b1, sda_now;
    logic [8:0] frame = 9'h0;
    logic       rd_mode = 1'b0;
    int         bitcnt = 0, cyc = 0, t_rise = 0, t_fall = 0;
    int         hi_meas = 0, lo_meas = 0;
    int         n_start = 0, n_stop = 0, n_wr_done = 0, n_rd_done = 0;
    logic [7:0] q_byte[$];
    logic       q_ack[$];

    always @(negedge clk) begin
        cyc++;
        if (wr_done) n_wr_done++;
        if (rd_done) n_rd_done++;
        sda_now = i2c_sda;
        if (prev_scl && i2c_scl && prev_sda && !sda_now) begin
            n_start++;
            bitcnt = 0;
        end else if (prev_scl && i2c_scl && !prev_sda && sda_now) begin
            n_stop++;
            bitcnt = 0;
        end
        if (!prev_scl && i2c_scl) begin
            if (q_byte.size() == 1 && bitcnt == 3) lo_meas = cyc - t_fall;
            t_rise = cyc;
            frame  = {frame[7:0], sda_now};
            bitcnt++;
            if (bitcnt == 9) begin
                q_byte.push_back(frame[8:1]);
                q_ack.push_back(frame[0]);
                rd_mode = !rd_mode && (frame[8:1] == 8'hE9) && !frame[0];
                bitcnt  = 0;
            end
        end
        if (prev_scl && !i2c_scl) begin
            if (q_byte.size() == 1 && bitcnt == 4) hi_meas = cyc - t_rise;
            t_fall = cyc;
            if (rd_mode && bitcnt < 8)        slv_low = !slv_byte[3'(7 - bitcnt)];
            else if (!rd_mode && bitcnt == 8) slv_low = ack_en;
            else                              slv_low = 1'b0;
        end
        prev_scl = i2c_scl;
        prev_sda = sda_now;
    end

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        while (8'(dut.u1.state_r) != 8'h01 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check_eq(tag, 32'(t < 3000), 32'd1);
    endtask

    initial begin
        int t, k, qb, st0, sp0, wd0, rd0;
        logic got;
        logic [7:0] wb[4];
        logic [7:0] rb[4];
        logic       ra[4];
        wb[0] = 8'hE8; wb[1] = 8'h00; wb[2] = 8'h00; wb[3] = 8'hAA;
        rb[0] = 8'hE8; rb[1] = 8'h23; rb[2] = 8'hE9; rb[3] = 8'h5A;
        ra[0] = 1'b0;  ra[1] = 1'b0;  ra[2] = 1'b0;  ra[3] = 1'b1;

        // reset held 200 ns
        repeat (10) @(negedge clk);
        check_eq("rst_scl",     32'(i2c_scl), 32'd1);
        check_eq("rst_is_out",  32'(is_out),  32'd1);
        check_eq("rst_sda",     32'(i2c_sda), 32'd1);
        check_eq("rst_wr_done", 32'(wr_done), 32'd0);
        check_eq("rst_rd_done", 32'(rd_done), 32'd0);
        check_eq("rst_rd_data", 32'(rd_data), 32'd0);
        check_eq("rst_state",   32'(dut.u1.state_r), 32'h01);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // write burst E8 00 00 AA
        qb = q_byte.size(); st0 = n_start; sp0 = n_stop; wd0 = n_wr_done;
        ack_en = 1'b1; wr_data = wb[0]; wr_req = 1'b1;
        t = 0; k = 0;
        while (k < 4 && t < 20000) begin
            @(negedge clk);
            t++;
            if (wr_done) begin
                k++;
                if (k < 4) wr_data = wb[k];
                else       wr_req  = 1'b0;
            end
        end
        check_eq("wr_budget", 32'(t < 20000), 32'd1);
        wait_idle("wr_idle_budget");
        repeat (20) @(negedge clk);
        check_eq("wr_done_cnt", 32'(n_wr_done - wd0), 32'd4);
        check_eq("wr_nbytes",   32'(q_byte.size() - qb), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check_eq("wr_byte", 32'(q_byte[qb + i]), 32'(wb[i]));
            check_eq("wr_ack",  32'(q_ack[qb + i]),  32'd0);
        end
        check_eq("wr_starts", 32'(n_start - st0), 32'd1);
        check_eq("wr_stops",  32'(n_stop - sp0),  32'd1);
        check_eq("wr_state",  32'(dut.u1.state_r), 32'h01);
        check_eq("scl_high_clk", 32'(hi_meas), 32'd62);
        check_eq("scl_low_clk",  32'(lo_meas), 32'd62);

        // random read: dev E8, reg 23, slave returns 5A
        qb = q_byte.size(); st0 = n_start; sp0 = n_stop; wd0 = n_wr_done; rd0 = n_rd_done;
        wr_data = rb[0]; rd_req = 1'b1;
        t = 0; k = 0; got = 1'b0;
        while (!got && t < 30000) begin
            @(negedge clk);
            t++;
            if (wr_done) begin
                k++;
                if (k == 1) wr_data = rb[1];
            end
            if (rd_done) begin
                got = 1'b1;
                rd_req = 1'b0;
                check_eq("rd_data", 32'(rd_data), 32'h5A);
            end
        end
        check_eq("rd_done_seen", 32'(got), 32'd1);
        wait_idle("rd_idle_budget");
        repeat (20) @(negedge clk);
        check_eq("rd_wr_done_cnt", 32'(n_wr_done - wd0), 32'd2);
        check_eq("rd_done_cnt",    32'(n_rd_done - rd0), 32'd1);
        check_eq("rd_nbytes",      32'(q_byte.size() - qb), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check_eq("rd_byte", 32'(q_byte[qb + i]), 32'(rb[i]));
            check_eq("rd_ack",  32'(q_ack[qb + i]),  32'(ra[i]));
        end
        check_eq("rd_starts", 32'(n_start - st0), 32'd2);
        check_eq("rd_stops",  32'(n_stop - sp0),  32'd1);
        check_eq("rd_state",  32'(dut.u1.state_r), 32'h01);

        // slave NACKs the device address
        qb = q_byte.size(); sp0 = n_stop; wd0 = n_wr_done;
        ack_en = 1'b0; wr_data = 8'hE8; wr_req = 1'b1;
        t = 0;
        while (n_stop == sp0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        wr_req = 1'b0;
        check_eq("nack_stop_budget", 32'(t < 5000), 32'd1);
        wait_idle("nack_idle_budget");
        repeat (20) @(negedge clk);
        check_eq("nack_wr_done", 32'(n_wr_done - wd0), 32'd0);
        check_eq("nack_nbytes",  32'(q_byte.size() - qb), 32'd1);
        check_eq("nack_byte",    32'(q_byte[qb]), 32'hE8);
        check_eq("nack_ack",     32'(q_ack[qb]),  32'd1);
        check_eq("nack_stops",   32'(n_stop - sp0), 32'd1);
        check_eq("nack_state",   32'(dut.u1.state_r), 32'h01);
        ack_en = 1'b1;

        // reset in the middle of the device-address byte
        wr_data = 8'hE8; wr_req = 1'b1;
        repeat (600) @(negedge clk);
        check_eq("mid_state_busy", 32'(dut.u1.state_r), 32'h04);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_scl",     32'(i2c_scl), 32'd1);
        check_eq("mid_rst_is_out",  32'(is_out),  32'd1);
        check_eq("mid_rst_sda",     32'(i2c_sda), 32'd1);
        check_eq("mid_rst_wr_done", 32'(wr_done), 32'd0);
        check_eq("mid_rst_rd_done", 32'(rd_done), 32'd0);
        check_eq("mid_rst_rd_data", 32'(rd_data), 32'd0);
        check_eq("mid_rst_state",   32'(dut.u1.state_r), 32'h01);
        wr_req = 1'b0;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
